// File: rtl/mem_arbiter_rr_if.sv
// Bus bundle between CPUS cores (instruction + data ports), the arbiter and one shared RAM.
// The arbiter uses the slave view; the cores/RAM side (or a bench) uses the master view.
interface mem_arbiter_rr_if #(
  parameter int CPUS = 2,
  parameter int AW   = 32,
  parameter int DW   = 32
);
  localparam int NSRC = 2 * CPUS;
  localparam int SW   = $clog2(NSRC);

  logic [CPUS-1:0]    iREN;
  logic [CPUS-1:0]    dREN;
  logic [CPUS-1:0]    dWEN;
  logic [CPUS*AW-1:0] iaddr;
  logic [CPUS*AW-1:0] daddr;
  logic [CPUS*DW-1:0] dstore;
  logic [CPUS-1:0]    iwait;
  logic [CPUS-1:0]    dwait;
  logic [CPUS*DW-1:0] iload;
  logic [CPUS*DW-1:0] dload;
  logic               ramREN;
  logic               ramWEN;
  logic [AW-1:0]      ramaddr;
  logic [DW-1:0]      ramstore;
  logic [DW-1:0]      ramload;
  logic [1:0]         ramstate;
  logic               grant_valid;
  logic [SW-1:0]      grant_src;
  logic               timeout_flag;

  modport slave (
    input  iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore,
           grant_valid, grant_src, timeout_flag
  );

  modport master (
    output iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
    input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore,
           grant_valid, grant_src, timeout_flag
  );
endinterface

// File: rtl/mem_arbiter_rr.sv
// Round-robin RAM arbiter: registered grant FSM (IDLE/BUSY/RELEASE) over CPUS cores' I and D ports,
// with data-over-instruction or flat priority, per-transaction timeout and a release cycle between grants.
module mem_arbiter_rr #(
  parameter int CPUS    = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int DPRIO   = 1,
  parameter int TIMEOUT = 255
) (
  input  logic            CLK,
  input  logic            RST,
  mem_arbiter_rr_if.slave bus
);
  localparam int NSRC = 2 * CPUS;
  localparam int SW   = $clog2(NSRC);
  localparam int PW   = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam logic [1:0] RS_ACCESS = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [PW-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [TW-1:0]   r_timer, w_timer_nxt;
  logic            r_tflag, w_tflag_nxt;

  logic [SW-1:0]   r_src;
  logic            r_op;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;

  logic            w_win_vld;
  logic [SW-1:0]   w_win_src;
  logic            w_win_op;
  logic [AW-1:0]   w_win_addr;
  logic [DW-1:0]   w_win_wdata;
  logic            w_held;
  logic [CPUS-1:0] w_dreq;

  assign w_dreq = bus.dREN | bus.dWEN;

  function automatic logic bit_at(input logic [CPUS-1:0] v, input int idx);
    logic b;
    b = 1'b0;
    for (int j = 0; j < CPUS; j++) begin
      if (j == idx) b = v[j];
    end
    return b;
  endfunction

  // Arbitration: first requester found scanning upward from the round-robin pointer
  always_comb begin : arb
    int c;
    int s;
    c         = 0;
    s         = 0;
    w_win_vld = 1'b0;
    w_win_src = '0;
    if (DPRIO != 0) begin
      for (int k = 0; k < CPUS; k++) begin
        c = int'(r_rr_ptr) + k;
        if (c >= CPUS) c = c - CPUS;
        if (!w_win_vld && bit_at(w_dreq, c)) begin
          w_win_vld = 1'b1;
          w_win_src = SW'(2 * c);
        end
      end
      for (int k = 0; k < CPUS; k++) begin
        c = int'(r_rr_ptr) + k;
        if (c >= CPUS) c = c - CPUS;
        if (!w_win_vld && bit_at(bus.iREN, c)) begin
          w_win_vld = 1'b1;
          w_win_src = SW'(2 * c + 1);
        end
      end
    end else begin
      for (int k = 0; k < NSRC; k++) begin
        s = 2 * int'(r_rr_ptr) + k;
        if (s >= NSRC) s = s - NSRC;
        if (!w_win_vld &&
            (((s % 2) == 1) ? bit_at(bus.iREN, s / 2) : bit_at(w_dreq, s / 2))) begin
          w_win_vld = 1'b1;
          w_win_src = SW'(s);
        end
      end
    end
  end

  // Payload of the winner; a simultaneous dREN+dWEN is treated as a write
  always_comb begin : payload
    w_win_op    = 1'b0;
    w_win_addr  = '0;
    w_win_wdata = '0;
    for (int j = 0; j < CPUS; j++) begin
      if (j == int'(w_win_src >> 1)) begin
        if (w_win_src[0]) begin
          w_win_addr = bus.iaddr[j*AW +: AW];
        end else begin
          w_win_op    = bus.dWEN[j];
          w_win_addr  = bus.daddr[j*AW +: AW];
          w_win_wdata = bus.dstore[j*DW +: DW];
        end
      end
    end
  end

  // The specific line that keeps the granted transaction alive
  always_comb begin : hold
    w_held = 1'b0;
    for (int j = 0; j < CPUS; j++) begin
      if (j == int'(r_src >> 1)) begin
        w_held = r_src[0] ? bus.iREN[j] : (r_op ? bus.dWEN[j] : bus.dREN[j]);
      end
    end
  end

  always_comb begin : fsm
    w_state_nxt      = r_state;
    w_rr_ptr_nxt     = r_rr_ptr;
    w_timer_nxt      = r_timer;
    w_tflag_nxt      = r_tflag;
    bus.iwait        = '1;
    bus.dwait        = '1;
    bus.iload        = '0;
    bus.dload        = '0;
    bus.ramREN       = 1'b0;
    bus.ramWEN       = 1'b0;
    bus.ramaddr      = '0;
    bus.ramstore     = '0;
    bus.grant_valid  = 1'b0;
    bus.grant_src    = '0;
    bus.timeout_flag = r_tflag;
    case (r_state)
      S_IDLE: begin
        if (w_win_vld) begin
          w_state_nxt = S_BUSY;
          w_timer_nxt = '0;
        end
      end
      S_BUSY: begin
        bus.grant_valid = 1'b1;
        bus.grant_src   = r_src;
        bus.ramaddr     = r_addr;
        bus.ramstore    = r_wdata;
        bus.ramWEN      = r_op;
        bus.ramREN      = ~r_op;
        if (bus.ramstate == RS_ACCESS) begin
          for (int j = 0; j < CPUS; j++) begin
            if (j == int'(r_src >> 1)) begin
              if (r_src[0]) begin
                bus.iwait[j] = 1'b0;
                if (!r_op) bus.iload[j*DW +: DW] = bus.ramload;
              end else begin
                bus.dwait[j] = 1'b0;
                if (!r_op) bus.dload[j*DW +: DW] = bus.ramload;
              end
              w_rr_ptr_nxt = (j + 1 >= CPUS) ? '0 : PW'(j + 1);
            end
          end
          w_state_nxt = S_RELEASE;
        end else if (!w_held) begin
          w_state_nxt = S_RELEASE;
        end else if (r_timer == TW'(TIMEOUT - 1)) begin
          w_state_nxt = S_RELEASE;
          w_tflag_nxt = 1'b1;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      S_RELEASE: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= '0;
      r_timer  <= '0;
      r_tflag  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_timer  <= w_timer_nxt;
      r_tflag  <= w_tflag_nxt;
    end
  end

  // Grant payload is only observed in BUSY, so it is captured without reset
  always_ff @(posedge CLK) begin
    if (r_state == S_IDLE && w_win_vld) begin
      r_src   <= w_win_src;
      r_op    <= w_win_op;
      r_addr  <= w_win_addr;
      r_wdata <= w_win_wdata;
    end
  end
endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr: two instances (DPRIO=1 and DPRIO=0, TIMEOUT=4) share stimulus and are
// compared every cycle against a transaction-level reference model.
module tb_mem_arbiter_rr;
  localparam int CPUS = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int TMO  = 4;
  localparam logic [1:0] RS_FREE = 2'd0, RS_BUSY = 2'd1, RS_ACCESS = 2'd2, RS_ERROR = 2'd3;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic [1:0]  t_iREN, t_dREN, t_dWEN;
  logic [63:0] t_iaddr, t_daddr, t_dstore;
  logic [31:0] t_ramload;
  logic [1:0]  t_ramstate;

  mem_arbiter_rr_if #(.CPUS(CPUS), .AW(AW), .DW(DW)) ifa ();
  mem_arbiter_rr_if #(.CPUS(CPUS), .AW(AW), .DW(DW)) ifb ();

  assign ifa.iREN = t_iREN;   assign ifb.iREN = t_iREN;
  assign ifa.dREN = t_dREN;   assign ifb.dREN = t_dREN;
  assign ifa.dWEN = t_dWEN;   assign ifb.dWEN = t_dWEN;
  assign ifa.iaddr = t_iaddr; assign ifb.iaddr = t_iaddr;
  assign ifa.daddr = t_daddr; assign ifb.daddr = t_daddr;
  assign ifa.dstore = t_dstore;     assign ifb.dstore = t_dstore;
  assign ifa.ramload = t_ramload;   assign ifb.ramload = t_ramload;
  assign ifa.ramstate = t_ramstate; assign ifb.ramstate = t_ramstate;

  mem_arbiter_rr #(.CPUS(CPUS), .AW(AW), .DW(DW), .DPRIO(1), .TIMEOUT(TMO)) dut_a (
    .CLK(CLK), .RST(RST), .bus(ifa.slave)
  );
  mem_arbiter_rr #(.CPUS(CPUS), .AW(AW), .DW(DW), .DPRIO(0), .TIMEOUT(TMO)) dut_b (
    .CLK(CLK), .RST(RST), .bus(ifb.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s observed=%h expected=%h", tag, got, exp);
  endtask

  // Reference model, per instance u (0: data-first, 1: flat order).
  // phase 0 idle, 1 transaction open, 2 release gap.
  int          m_ph[2], m_src[2], m_age[2], m_ptr[2];
  bit          m_wr[2], m_tf[2];
  logic [31:0] m_addr[2], m_data[2];
  int          n_ph[2], n_src[2], n_age[2], n_ptr[2];
  bit          n_wr[2], n_tf[2];
  logic [31:0] n_addr[2], n_data[2];

  function automatic bit bitof(input logic [1:0] v, input int i);
    return ((v >> i) & 2'b01) != 2'b00;
  endfunction

  function automatic int pick(input int u);
    int p, c, s;
    p = m_ptr[u];
    if (u == 0) begin
      for (int k = 0; k < CPUS; k++) begin
        c = (p + k) % CPUS;
        if (bitof(t_dREN | t_dWEN, c)) return 2 * c;
      end
      for (int k = 0; k < CPUS; k++) begin
        c = (p + k) % CPUS;
        if (bitof(t_iREN, c)) return 2 * c + 1;
      end
    end else begin
      for (int k = 0; k < 2 * CPUS; k++) begin
        s = (2 * p + k) % (2 * CPUS);
        if ((s % 2 == 1) ? bitof(t_iREN, s / 2) : bitof(t_dREN | t_dWEN, s / 2)) return s;
      end
    end
    return -1;
  endfunction

  task automatic eval_dut(input int u);
    logic [1:0]  o_iw, o_dw, o_gs, e_iw, e_dw, e_gs;
    logic [63:0] o_il, o_dl, e_il, e_dl;
    logic        o_ren, o_wen, o_gv, o_tf, e_ren, e_wen, e_gv, e_tf;
    logic [31:0] o_ad, o_st, e_ad, e_st;
    int          w, c, core;
    bit          held;
    string       p;
    if (u == 0) begin
      o_iw = ifa.iwait; o_dw = ifa.dwait; o_il = ifa.iload; o_dl = ifa.dload;
      o_ren = ifa.ramREN; o_wen = ifa.ramWEN; o_ad = ifa.ramaddr; o_st = ifa.ramstore;
      o_gv = ifa.grant_valid; o_gs = ifa.grant_src; o_tf = ifa.timeout_flag;
    end else begin
      o_iw = ifb.iwait; o_dw = ifb.dwait; o_il = ifb.iload; o_dl = ifb.dload;
      o_ren = ifb.ramREN; o_wen = ifb.ramWEN; o_ad = ifb.ramaddr; o_st = ifb.ramstore;
      o_gv = ifb.grant_valid; o_gs = ifb.grant_src; o_tf = ifb.timeout_flag;
    end
    e_iw = 2'b11; e_dw = 2'b11; e_il = '0; e_dl = '0; e_ren = 1'b0; e_wen = 1'b0;
    e_ad = '0; e_st = '0; e_gv = 1'b0; e_gs = '0; e_tf = m_tf[u];
    n_ph[u] = m_ph[u]; n_src[u] = m_src[u]; n_age[u] = m_age[u]; n_ptr[u] = m_ptr[u];
    n_wr[u] = m_wr[u]; n_tf[u] = m_tf[u]; n_addr[u] = m_addr[u]; n_data[u] = m_data[u];
    core = m_src[u] / 2;
    if (m_ph[u] == 0) begin
      w = pick(u);
      if (w >= 0) begin
        c = w / 2;
        n_ph[u] = 1; n_src[u] = w; n_age[u] = 0;
        if (w % 2 == 1) begin
          n_wr[u] = 1'b0; n_addr[u] = 32'(t_iaddr >> (32 * c)); n_data[u] = '0;
        end else begin
          n_wr[u] = bitof(t_dWEN, c);
          n_addr[u] = 32'(t_daddr >> (32 * c));
          n_data[u] = 32'(t_dstore >> (32 * c));
        end
      end
    end else if (m_ph[u] == 1) begin
      e_gv = 1'b1; e_gs = 2'(m_src[u]); e_ad = m_addr[u]; e_st = m_data[u];
      e_wen = m_wr[u]; e_ren = !m_wr[u];
      if (t_ramstate == RS_ACCESS) begin
        if (m_src[u] % 2 == 1) begin
          e_iw = e_iw & ~(2'b01 << core);
          if (!m_wr[u]) e_il = 64'(t_ramload) << (32 * core);
        end else begin
          e_dw = e_dw & ~(2'b01 << core);
          if (!m_wr[u]) e_dl = 64'(t_ramload) << (32 * core);
        end
        n_ph[u] = 2; n_ptr[u] = (core + 1) % CPUS;
      end else begin
        if (m_src[u] % 2 == 1) held = bitof(t_iREN, core);
        else if (m_wr[u])      held = bitof(t_dWEN, core);
        else                   held = bitof(t_dREN, core);
        if (!held) n_ph[u] = 2;
        else if (m_age[u] + 1 == TMO) begin n_ph[u] = 2; n_tf[u] = 1'b1; end
        else n_age[u] = m_age[u] + 1;
      end
    end else begin
      n_ph[u] = 0;
    end
    if (RST) begin n_ph[u] = 0; n_ptr[u] = 0; n_age[u] = 0; n_tf[u] = 1'b0; end
    p = $sformatf("u%0d c%0d ", u, cyc);
    check_eq({p, "iwait"}, 64'(o_iw), 64'(e_iw));
    check_eq({p, "dwait"}, 64'(o_dw), 64'(e_dw));
    check_eq({p, "iload"}, o_il, e_il);
    check_eq({p, "dload"}, o_dl, e_dl);
    check_eq({p, "ramREN"}, 64'(o_ren), 64'(e_ren));
    check_eq({p, "ramWEN"}, 64'(o_wen), 64'(e_wen));
    check_eq({p, "ramaddr"}, 64'(o_ad), 64'(e_ad));
    check_eq({p, "ramstore"}, 64'(o_st), 64'(e_st));
    check_eq({p, "grant_valid"}, 64'(o_gv), 64'(e_gv));
    check_eq({p, "grant_src"}, 64'(o_gs), 64'(e_gs));
    check_eq({p, "timeout_flag"}, 64'(o_tf), 64'(e_tf));
  endtask

  task automatic cycle();
    @(negedge CLK);
    eval_dut(0);
    eval_dut(1);
    @(posedge CLK);
    for (int u = 0; u < 2; u++) begin
      m_ph[u] = n_ph[u]; m_src[u] = n_src[u]; m_age[u] = n_age[u]; m_ptr[u] = n_ptr[u];
      m_wr[u] = n_wr[u]; m_tf[u] = n_tf[u]; m_addr[u] = n_addr[u]; m_data[u] = n_data[u];
    end
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    t_iREN = '0; t_dREN = '0; t_dWEN = '0;
    t_iaddr = '0; t_daddr = '0; t_dstore = '0;
    t_ramload = '0; t_ramstate = RS_FREE;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST = 1'b1;
    cycle();
    RST = 1'b0;
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      m_ph[u] = 0; m_src[u] = 0; m_age[u] = 0; m_ptr[u] = 0;
      m_wr[u] = 1'b0; m_tf[u] = 1'b0; m_addr[u] = '0; m_data[u] = '0;
    end
    idle_inputs();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    do_reset();
    check_eq("reset grant_valid", 64'(ifa.grant_valid), 64'd0);
    check_eq("reset dwait", 64'(ifa.dwait), 64'h3);

    // Single D read, ACCESS on the second BUSY cycle
    t_dREN = 2'b01; t_daddr = 64'h100;
    cycle();
    cycle();
    t_ramstate = RS_ACCESS; t_ramload = 32'hDEADBEEF;
    #1;
    check_eq("dread dwait0", 64'(ifa.dwait), 64'h2);
    check_eq("dread dload0", ifa.dload, 64'hDEADBEEF);
    t_dREN = '0;
    repeat (3) cycle();

    // Fairness: both cores stream D reads with immediate ACCESS
    do_reset();
    t_dREN = 2'b11; t_daddr = {32'h2000, 32'h1000}; t_ramstate = RS_ACCESS; t_ramload = 32'h1234;
    repeat (13) cycle();
    idle_inputs();
    repeat (2) cycle();

    // Priority: I0 and D1 write raised together
    do_reset();
    t_iREN = 2'b01; t_iaddr = 64'h80; t_dWEN = 2'b10; t_dstore = {32'h55, 32'h0};
    cycle();
    check_eq("prio a grant_src", 64'(ifa.grant_src), 64'd2);
    check_eq("prio a ramWEN", 64'(ifa.ramWEN), 64'd1);
    check_eq("prio a ramstore", 64'(ifa.ramstore), 64'h55);
    check_eq("prio b grant_src", 64'(ifb.grant_src), 64'd1);
    t_ramstate = RS_ACCESS; t_ramload = 32'hCAFE0001;
    cycle();
    t_dWEN = '0;
    repeat (6) cycle();
    idle_inputs();
    repeat (2) cycle();

    // Timeout with RAM held BUSY, then sticky flag
    do_reset();
    t_dREN = 2'b01; t_daddr = 64'h300; t_ramstate = RS_BUSY;
    repeat (7) cycle();
    check_eq("timeout flag a", 64'(ifa.timeout_flag), 64'd1);
    check_eq("timeout flag b", 64'(ifb.timeout_flag), 64'd1);
    t_dREN = '0;
    repeat (4) cycle();
    check_eq("timeout sticky", 64'(ifa.timeout_flag), 64'd1);

    // Abort by request drop in the second BUSY cycle
    do_reset();
    check_eq("reset clears flag", 64'(ifa.timeout_flag), 64'd0);
    t_dREN = 2'b01; t_daddr = 64'h500; t_ramstate = RS_FREE;
    cycle();
    cycle();
    t_dREN = '0;
    repeat (3) cycle();

    // Reset in the middle of BUSY
    t_dREN = 2'b10; t_daddr = 64'h600_0000_0000; t_ramstate = RS_BUSY;
    cycle();
    cycle();
    RST = 1'b1;
    cycle();
    RST = 1'b0;
    check_eq("midrst grant_valid", 64'(ifa.grant_valid), 64'd0);
    check_eq("midrst ramREN", 64'(ifa.ramREN), 64'd0);
    t_dREN = '0;
    repeat (2) cycle();

    // dREN and dWEN together: performed as a write
    t_dREN = 2'b01; t_dWEN = 2'b01; t_daddr = 64'h40; t_dstore = 64'h77;
    t_ramstate = RS_ACCESS; t_ramload = 32'hFFFF0000;
    cycle();
    check_eq("overlap ramWEN", 64'(ifa.ramWEN), 64'd1);
    check_eq("overlap ramREN", 64'(ifa.ramREN), 64'd0);
    check_eq("overlap dload", ifa.dload, 64'd0);
    idle_inputs();
    repeat (3) cycle();

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      int r;
      if ($urandom_range(2) == 0) t_iREN = 2'($urandom);
      if ($urandom_range(2) == 0) t_dREN = 2'($urandom);
      if ($urandom_range(3) == 0) t_dWEN = 2'($urandom);
      t_iaddr = {$urandom, $urandom};
      t_daddr = {$urandom, $urandom};
      t_dstore = {$urandom, $urandom};
      t_ramload = $urandom;
      r = $urandom_range(7);
      t_ramstate = (r < 4) ? RS_ACCESS : (r < 6) ? RS_BUSY : (r == 6) ? RS_FREE : RS_ERROR;
      RST = ($urandom_range(99) == 0);
      cycle();
    end
    RST = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
Parametrised RAM arbiter between CPUS cores, each with one instruction port and one data port, and a single shared RAM. It replaces fixed data-over-instruction combinational steering with a registered grant FSM and round-robin fairness across cores. It adds a configurable data/instruction priority mode, a per-transaction timeout with abort, and a clean release cycle between transactions.

Parameters:
CPUS, 2, number of cores (1..8); source count NSRC = 2*CPUS
AW, 32, address width
DW, 32, data width
DPRIO, 1, 1 = any data request beats any instruction request; 0 = single round-robin over D0,I0,D1,I1,...
TIMEOUT, 255, BUSY cycles without ACCESS before abort (counter width $clog2(TIMEOUT+1))

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous reset, active-high
iREN  in  CPUS  instruction read request per core
dREN  in  CPUS  data read request per core
dWEN  in  CPUS  data write request per core
iaddr  in  CPUS*AW  instruction address, core i at [i*AW +: AW]
daddr  in  CPUS*AW  data address per core
dstore  in  CPUS*DW  write data per core
iwait  out  CPUS  instruction wait, active-high
dwait  out  CPUS  data wait, active-high
iload  out  CPUS*DW  instruction read data
dload  out  CPUS*DW  data read data
ramREN  out  1  RAM read strobe
ramWEN  out  1  RAM write strobe
ramaddr  out  AW  RAM address
ramstore  out  DW  RAM write data
ramload  in  DW  RAM read data
ramstate  in  2  cpu_types_pkg ramstate_t (FREE, BUSY, ACCESS, ERROR)
grant_valid  out  1  a transaction is in BUSY
grant_src  out  $clog2(NSRC)  granted source index, 2*core + (1 if I-port)
timeout_flag  out  1  sticky, set on any timeout abort

Behaviour:
- Reset: RST=1 at a rising edge forces state IDLE, rr_ptr=0, timer=0, and timeout_flag=0. While in IDLE, all waits are 1, loads are 0, ramREN=ramWEN=0, ramaddr=0, ramstore=0, grant_valid=0, and grant_src=0. RST mid-transaction aborts immediately; RAM strobes are low in the cycle after that edge.
- States: IDLE, BUSY, RELEASE.
- IDLE:
  - A core's D request is dREN|dWEN. Its I request is iREN.
  - DPRIO=1: if any D request is present, pick the first requesting core scanning from rr_ptr upward, modulo CPUS. Otherwise, pick the first I request by the same scan.
  - DPRIO=0: scan the 2*CPUS sources starting at source 2*rr_ptr.
  - If a winner exists, register grant_src, op (write if dWEN, else read; dWEN wins over a simultaneous dREN), addr, and wdata. Go to BUSY with timer=0.
- BUSY:
  - Drive ramaddr and ramstore from the latched values. Drive ramWEN=op or ramREN=~op.
  - grant_valid=1.
  - If ramstate==ACCESS: the granted wait=0 combinationally in this cycle. For reads, the granted load=ramload in this cycle. Next state is RELEASE and rr_ptr = (granted core+1) mod CPUS.
  - Else if the granted request line drops: abort, with no wait pulse, and go to RELEASE. The request line is dWEN for writes, dREN for D reads, iREN for I reads.
  - Else if timer==TIMEOUT-1: abort, set timeout_flag, and go to RELEASE.
  - Else timer++. ERROR and FREE are treated as BUSY.
- RELEASE:
  - One cycle with no RAM strobes and all waits=1.
  - Go to IDLE unconditionally, so a requester sees at least one wait=1 cycle before re-arbitration.
- Non-granted sources always see wait=1 and load=0.
- Latency: a request present at edge N enters BUSY at N+1. With ramstate==ACCESS on that first BUSY cycle, wait=0 occurs in cycle N+1. Minimum issue interval for back-to-back transactions is 3 cycles.
- Address and data are latched at grant. Changes by the requester during BUSY do not reach the RAM.
- CPUS=1 degenerates to a single core with D-over-I priority; rr_ptr stays 0.

Test Plan:
- Single D read: core0 dREN=1, daddr=0x100; RAM returns ACCESS on the 2nd BUSY cycle with ramload=0xDEADBEEF -> ramREN=1, ramaddr=0x100 for 2 cycles; dwait[0]=0 and dload[0]=0xDEADBEEF for exactly 1 cycle; then RELEASE, then IDLE.
- Fairness: CPUS=2, both cores continuously assert dREN, ACCESS immediate -> grants alternate 0,1,0,1 (grant_src 0,2,0,2), each core served once per 6 cycles.
- Priority, DPRIO=1: core0 iREN and core1 dWEN (dstore=0x55) raised in the same cycle -> core1 write is granted first (ramWEN=1, ramstore=0x55), then core0 fetch. With DPRIO=0 and rr_ptr=0 -> I0 is granted first.
- Timeout: TIMEOUT=4, ramstate held BUSY -> after 4 BUSY cycles the FSM moves to RELEASE; timeout_flag=1 and stays 1; dwait never drops.
- Abort and reset: requester drops dREN in the 2nd BUSY cycle -> RAM strobes low next cycle, no wait pulse. Separately, RST=1 during BUSY -> all outputs at reset values after that edge, rr_ptr=0.
- Write/read overlap: one core asserts dREN and dWEN together at addr 0x40 -> a write is performed (ramWEN=1, ramREN=0), and dload stays 0.
